port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter.sv | 145 ++++++++++++++
 tb/tb_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_arbiter.sv
// Output-port arbiter for a 3-input router: round-robin grant per output.
// Define PORT_ARB_AGING_EN to add age counters that give starving inputs priority.
module port_arbiter #(
    parameter int unsigned AGE_MAX = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] dout_x,
    input  logic [1:0] dout_y,
    input  logic [1:0] dout_local,
    output logic [1:0] grant_x,
    output logic [1:0] grant_y,
    output logic [1:0] grant_local,
    output logic [2:0] fail,
    output logic       starve
);

    if (AGE_MAX < 1 || AGE_MAX > 7) begin : g_bad_age
        $error("AGE_MAX must be within 1..7");
    end

    // Index 0 = X, 1 = Y, 2 = LOCAL; grant code is index + 1
    logic [1:0] dir    [3];
    logic [1:0] ptr_q  [3];
    logic [1:0] ptr_d  [3];
    logic [1:0] gnt_q  [3];
    logic [1:0] gnt_d  [3];
    logic [2:0] fail_q;
    logic [2:0] fail_d;
    logic [2:0] urg;
    logic [2:0] active;
    logic [2:0] won;
    logic [2:0] req;
    logic [2:0] cand;
    logic [2:0] sum;
    logic [1:0] idx;
    logic       hit;

    assign dir[0] = dout_x;
    assign dir[1] = dout_y;
    assign dir[2] = dout_local;

    assign active = {dout_local != 2'b00,
                     dout_y != 2'b00,
                     dout_x != 2'b00};

    always_comb begin
        won    = '0;
        fail_d = '0;
        req    = '0;
        cand   = '0;
        sum    = '0;
        idx    = '0;
        hit    = 1'b0;
        for (int p = 0; p < 3; p++) begin
            gnt_d[p] = 2'b00;
            ptr_d[p] = ptr_q[p];
            for (int i = 0; i < 3; i++) begin
                req[i] = (dir[i] == 2'(p + 1));
            end
            cand = (|(req & urg)) ? (req & urg) : req;
            hit  = 1'b0;
            for (int k = 0; k < 3; k++) begin
                sum = {1'b0, ptr_q[p]} + 3'(k);
                idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                if (!hit && cand[idx]) begin
                    hit      = 1'b1;
                    gnt_d[p] = idx + 2'd1;
                    ptr_d[p] = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                    won[idx] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            fail_d[2 - i] = active[i] & ~won[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) begin
                gnt_q[p] <= 2'b00;
                ptr_q[p] <= 2'b00;
            end
            fail_q <= 3'b000;
        end else if (enable) begin
            for (int p = 0; p < 3; p++) begin
                gnt_q[p] <= gnt_d[p];
                ptr_q[p] <= ptr_d[p];
            end
            fail_q <= fail_d;
        end
    end

    assign grant_x     = gnt_q[0];
    assign grant_y     = gnt_q[1];
    assign grant_local = gnt_q[2];
    assign fail        = fail_q;

`ifdef PORT_ARB_AGING_EN
    localparam logic [2:0] AGE_LIM = 3'(AGE_MAX);

    logic [2:0] age_q [3];
    logic [2:0] age_d [3];
    logic       starve_q;
    logic       starve_d;

    assign urg = {age_q[2] == AGE_LIM,
                  age_q[1] == AGE_LIM,
                  age_q[0] == AGE_LIM};

    assign starve_d = |(urg & active);

    // Count consecutive losses, saturating once urgent
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            age_d[i] = 3'd0;
            if (fail_d[2 - i]) begin
                age_d[i] = urg[i] ? age_q[i] : age_q[i] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                age_q[i] <= 3'd0;
            end
            starve_q <= 1'b0;
        end else if (enable) begin
            for (int i = 0; i < 3; i++) begin
                age_q[i] <= age_d[i];
            end
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign urg    = 3'b000;
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_port_arbiter.sv
// Randomized and directed bench for port_arbiter against a queue-based model.
// Builds with or without PORT_ARB_AGING_EN; aging runs use AGE_MAX = 1.
module tb_port_arbiter;

`ifdef PORT_ARB_AGING_EN
    localparam int AGE   = 1;
    localparam bit AGING = 1'b1;
`else
    localparam int AGE   = 7;
    localparam bit AGING = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] dout_x = 2'b00;
    logic [1:0] dout_y = 2'b00;
    logic [1:0] dout_local = 2'b00;
    logic [1:0] grant_x;
    logic [1:0] grant_y;
    logic [1:0] grant_local;
    logic [2:0] fail;
    logic       starve;

    int n_vec = 0;
    int n_err = 0;

    int         m_ptr [3];
    int         m_age [3];
    logic [1:0] m_gnt [3];
    logic [2:0] m_fail;
    logic       m_starve;

    port_arbiter #(.AGE_MAX(AGE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .dout_x(dout_x),
        .dout_y(dout_y),
        .dout_local(dout_local),
        .grant_x(grant_x),
        .grant_y(grant_y),
        .grant_local(grant_local),
        .fail(fail),
        .starve(starve)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ptr[i] = 0;
            m_age[i] = 0;
            m_gnt[i] = 2'b00;
        end
        m_fail   = 3'b000;
        m_starve = 1'b0;
    endtask

    // Each output scans inputs from its pointer; urgent requesters filter first
    task automatic model_step(input logic [1:0] dx, input logic [1:0] dy,
                              input logic [1:0] dl);
        int dir [3];
        bit urgent [3];
        bit won [3];
        int order [$];
        bit any_urg;
        bit f;
        int j;
        dir[0] = int'(dx);
        dir[1] = int'(dy);
        dir[2] = int'(dl);
        m_starve = 1'b0;
        for (int i = 0; i < 3; i++) begin
            urgent[i] = AGING && (m_age[i] == AGE);
            won[i] = 1'b0;
            if (dir[i] != 0 && urgent[i]) m_starve = 1'b1;
        end
        for (int p = 0; p < 3; p++) begin
            any_urg = 1'b0;
            for (int i = 0; i < 3; i++)
                if (dir[i] == p + 1 && urgent[i]) any_urg = 1'b1;
            order.delete();
            for (int k = 0; k < 3; k++) begin
                j = (m_ptr[p] + k) % 3;
                if (dir[j] == p + 1 && (!any_urg || urgent[j]))
                    order.push_back(j);
            end
            m_gnt[p] = 2'b00;
            if (order.size() > 0) begin
                m_gnt[p] = 2'(order[0] + 1);
                m_ptr[p] = (order[0] + 1) % 3;
                won[order[0]] = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            f = (dir[i] != 0) && !won[i];
            m_fail[2 - i] = f;
            if (AGING) m_age[i] = f ? ((m_age[i] + 1 > AGE) ? AGE : m_age[i] + 1) : 0;
        end
    endtask

    task automatic step(input logic [1:0] dx, input logic [1:0] dy,
                        input logic [1:0] dl, input logic en);
        @(negedge clk);
        dout_x = dx;
        dout_y = dy;
        dout_local = dl;
        enable = en;
        @(posedge clk);
        if (en) model_step(dx, dy, dl);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        dout_x = 2'b00;
        dout_y = 2'b00;
        dout_local = 2'b00;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        n_vec++;
        if ({grant_x, grant_y, grant_local, fail, starve} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_init got %b required 0",
                     {grant_x, grant_y, grant_local, fail, starve});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b10, 2'b10, 2'b01, 1'b1);
        step(2'b11, 2'b10, 2'b10, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({grant_x, grant_y, grant_local, fail, starve} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_async got %b required 0",
                     {grant_x, grant_y, grant_local, fail, starve});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b10, 2'b10, 2'b10, 1'b1);
        n_vec++;
        if (grant_y !== 2'b01 || fail !== 3'b011) begin
            n_err++;
            $display("FAIL reset_first got %b/%b required 01/011", grant_y, fail);
        end
    endtask

    task automatic test_contention();
        logic [1:0] eg [3];
        logic [2:0] ef [3];
        eg = '{2'b01, 2'b10, 2'b11};
        ef = '{3'b011, 3'b101, 3'b110};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(2'b10, 2'b10, 2'b10, 1'b1);
            n_vec++;
            if (grant_y !== eg[c] || fail !== ef[c] || grant_x !== 2'b00 ||
                grant_local !== 2'b00 || starve !== m_starve) begin
                n_err++;
                $display("FAIL contention c%0d got %b/%b/%b required %b/%b/%b",
                         c, grant_y, fail, starve, eg[c], ef[c], m_starve);
            end
        end
    endtask

    task automatic test_disjoint();
        do_reset();
        step(2'b10, 2'b11, 2'b01, 1'b1);
        n_vec++;
        if (grant_x !== 2'b11 || grant_y !== 2'b01 ||
            grant_local !== 2'b10 || fail !== 3'b000) begin
            n_err++;
            $display("FAIL disjoint got x%b y%b l%b f%b required x11 y01 l10 f000",
                     grant_x, grant_y, grant_local, fail);
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(2'b10, 2'b10, 2'b10, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(2'($urandom), 2'($urandom), 2'($urandom), 1'b0);
            n_vec++;
            if (grant_y !== 2'b01 || fail !== 3'b011 || grant_x !== 2'b00 ||
                grant_local !== 2'b00 || starve !== m_starve) begin
                n_err++;
                $display("FAIL hold c%0d got %b/%b required 01/011", c, grant_y, fail);
            end
        end
        step(2'b10, 2'b10, 2'b10, 1'b1);
        n_vec++;
        if (grant_y !== 2'b10) begin
            n_err++;
            $display("FAIL hold_resume got %b required 10", grant_y);
        end
    endtask

    task automatic test_aging();
        do_reset();
        step(2'b10, 2'b00, 2'b10, 1'b1);
        n_vec++;
        if (grant_y !== 2'b01 || fail !== 3'b001) begin
            n_err++;
            $display("FAIL aging_c1 got %b/%b required 01/001", grant_y, fail);
        end
        step(2'b00, 2'b10, 2'b10, 1'b1);
        n_vec++;
        if (AGING) begin
            if (grant_y !== 2'b11 || fail !== 3'b010 || starve !== 1'b1) begin
                n_err++;
                $display("FAIL aging_c2 got %b/%b/%b required 11/010/1",
                         grant_y, fail, starve);
            end
        end else begin
            if (grant_y !== 2'b10 || fail !== 3'b001 || starve !== 1'b0) begin
                n_err++;
                $display("FAIL aging_c2 got %b/%b/%b required 10/001/0",
                         grant_y, fail, starve);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            step(2'($urandom), 2'($urandom), 2'($urandom),
                 $urandom_range(0, 4) != 0);
            n_vec++;
            if (grant_x !== m_gnt[0] || grant_y !== m_gnt[1] ||
                grant_local !== m_gnt[2]) begin
                n_err++;
                $display("FAIL rand_grant c%0d got %b%b%b required %b%b%b", c,
                         grant_x, grant_y, grant_local, m_gnt[0], m_gnt[1], m_gnt[2]);
            end
            n_vec++;
            if (fail !== m_fail || starve !== m_starve) begin
                n_err++;
                $display("FAIL rand_fail c%0d got %b/%b required %b/%b", c,
                         fail, starve, m_fail, m_starve);
            end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_disjoint();
        test_hold();
        test_aging();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
